// File: rtl/pio_edge_irq_gen2.sv
// Avalon-MM input PIO: synchroniser, edge select, W1C capture, masked IRQ.
// Define PIO_EDGE_DEBOUNCE_EN to add the per-bit debounce filter.
module pio_edge_irq_gen2 #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16,
  parameter int DB_RESET    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_RISE = 3'd4;
  localparam logic [2:0] A_FALL = 3'd5;
  localparam logic [2:0] A_DB   = 3'd6;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [31:0]      db_rd;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr  = chipselect & ~write_n;
  assign wd  = writedata[WIDTH-1:0];
  assign s   = sync_q[SYNC_STAGES-1];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef PIO_EDGE_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_period;
  logic [DB_CNT_W-1:0] cnt [WIDTH];

  assign db_rd = 32'(db_period);

  always_ff @(posedge clk) begin
    if (reset)
      db_period <= DB_CNT_W'(DB_RESET);
    else if (wr && address == A_DB)
      db_period <= writedata[DB_CNT_W-1:0];
  end

  // >= compare so a shrunk period never leaves a counter stranded
  always_ff @(posedge clk) begin
    if (reset) begin
      f <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == f[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= db_period) begin
          f[i]   <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end
`else
  assign f     = s;
  assign db_rd = '0;
`endif

  assign ev  = (rise_en & f & ~f_d) | (fall_en & ~f & f_d);
  assign clr = (wr && address == A_CAP) ? wd : '0;
  assign irq = |(cap & mask);

  always_comb begin
    rd_mux = '0;
    unique case (address)
      A_DATA:  rd_mux[WIDTH-1:0] = f;
      A_MASK:  rd_mux[WIDTH-1:0] = mask;
      A_CAP:   rd_mux[WIDTH-1:0] = cap;
      A_RISE:  rd_mux[WIDTH-1:0] = rise_en;
      A_FALL:  rd_mux[WIDTH-1:0] = fall_en;
      A_DB:    rd_mux = db_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_d      <= '0;
      cap      <= '0;
      mask     <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
      readdata <= '0;
    end else begin
      f_d      <= f;
      readdata <= rd_mux;
      // a new event beats a same-cycle clear
      cap      <= (cap & ~clr) | ev;
      if (wr) begin
        unique case (1'b1)
          address == A_MASK: mask    <= wd;
          address == A_RISE: rise_en <= wd;
          address == A_FALL: fall_en <= wd;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_edge_irq_gen2.sv
// Randomised bench for pio_edge_irq_gen2 against a cycle-level reference model.
// Directed scenarios first, then random bus traffic and input toggling.
module tb_pio_edge_irq_gen2;

  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int DBR = 1000;

`ifdef PIO_EDGE_DEBOUNCE_EN
  localparam int LAT = SS + 6;
`else
  localparam int LAT = SS + 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic          irq;
  logic [31:0]   readdata;

  always #5 clk = ~clk;

  pio_edge_irq_gen2 #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DB_CNT_W(16),
    .DB_RESET(DBR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .irq(irq),
    .readdata(readdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [W-1:0] pipe[$];
  logic [W-1:0] m_f, m_fd, m_cap, m_mask, m_rise, m_fall;
  logic [31:0]  m_per, m_rd;
  int           run [W];

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < SS; i++) pipe.push_back('0);
    m_f = '0; m_fd = '0; m_cap = '0; m_mask = '0;
    m_rise = '1; m_fall = '0; m_per = DBR; m_rd = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endfunction

  function automatic logic [31:0] view(logic [2:0] a);
    case (a)
      3'd0: return 32'(m_f);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
      3'd4: return 32'(m_rise);
      3'd5: return 32'(m_fall);
`ifdef PIO_EDGE_DEBOUNCE_EN
      3'd6: return m_per;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] s, ev, clr;
    logic [31:0]  rd;
    logic         wr;
    if (reset) begin
      model_reset();
      return;
    end
    wr  = chipselect && !write_n;
    s   = pipe[0];
    rd  = view(address);
    ev  = (m_rise & m_f & ~m_fd) | (m_fall & ~m_f & m_fd);
    clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    m_cap = (m_cap & ~clr) | ev;
    m_fd  = m_f;
`ifdef PIO_EDGE_DEBOUNCE_EN
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_f[i]) run[i] = 0;
      else if (run[i] >= int'(m_per)) begin
        m_f[i] = s[i];
        run[i] = 0;
      end else run[i]++;
    end
`endif
    if (wr) begin
      case (address)
        3'd2: m_mask = writedata[W-1:0];
        3'd4: m_rise = writedata[W-1:0];
        3'd5: m_fall = writedata[W-1:0];
        3'd6: m_per  = {16'h0, writedata[15:0]};
        default: ;
      endcase
    end
    pipe.push_back(in_port);
    void'(pipe.pop_front());
`ifndef PIO_EDGE_DEBOUNCE_EN
    m_f = pipe[0];
`endif
    m_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
    check("rdata", readdata, m_rd);
  endtask

  task automatic bus_write(logic [2:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  int n;

  initial begin
    model_reset();
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;

    // reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_rdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    in_port = 8'h00;
    bus_read(3'd4);
    check("rst_rise", readdata, 32'hFF);
    bus_read(3'd6);
`ifdef PIO_EDGE_DEBOUNCE_EN
    check("rst_db", readdata, 32'd1000);
    bus_write(3'd6, 32'd4);
`else
    check("rst_db", readdata, 32'h0);
`endif
    repeat (16) tick();
    bus_write(3'd3, 32'hFF);

    // rising edge latency and W1C clear
    bus_write(3'd2, 32'h01);
    bus_write(3'd4, 32'h01);
    bus_write(3'd5, 32'h00);
    in_port = 8'h01;
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq && n < 50);
    check("t2_lat", n, LAT);
    bus_read(3'd3);
    check("t2_cap", readdata, 32'h01);
    bus_write(3'd3, 32'h01);
    check("t2_clr", 32'(irq), 32'h0);

    // falling-only edge select
    bus_write(3'd4, 32'h00);
    bus_write(3'd5, 32'h80);
    in_port = 8'h81;
    repeat (16) tick();
    bus_write(3'd3, 32'hFF);
    in_port = 8'h01;
    repeat (16) tick();
    bus_read(3'd3);
    check("t3_fall", readdata, 32'h80);
    in_port = 8'h81;
    repeat (16) tick();
    bus_read(3'd3);
    check("t3_rise_ign", readdata, 32'h80);

    // W1C collides with a new event on bit 0
    bus_write(3'd5, 32'h00);
    bus_write(3'd4, 32'h03);
    bus_write(3'd2, 32'h03);
    in_port = 8'h00;
    repeat (16) tick();
    in_port = 8'h02;
    repeat (16) tick();
    bus_read(3'd3);
    check("t4_pre", readdata, 32'h82);
    in_port = 8'h03;
    repeat (LAT - 1) tick();
    bus_write(3'd3, 32'h03);
    bus_read(3'd3);
    check("t4_coll", readdata, 32'h81);

`ifdef PIO_EDGE_DEBOUNCE_EN
    // short glitch filtered, long pulse accepted
    bus_write(3'd3, 32'hFF);
    bus_write(3'd4, 32'h04);
    in_port = 8'h07;
    repeat (3) tick();
    in_port = 8'h03;
    repeat (16) tick();
    bus_read(3'd3);
    check("t5_glitch_cap", readdata, 32'h0);
    bus_read(3'd0);
    check("t5_glitch_dat", readdata, 32'h03);
    in_port = 8'h07;
    repeat (6) tick();
    in_port = 8'h03;
    repeat (16) tick();
    bus_read(3'd3);
    check("t5_pulse_cap", readdata, 32'h04);
`endif

    // multi-bit both edges
    bus_write(3'd4, 32'hFF);
    bus_write(3'd5, 32'hFF);
    in_port = 8'h00;
    repeat (16) tick();
    bus_write(3'd3, 32'hFF);
    in_port = 8'hA5;
    repeat (16) tick();
    bus_read(3'd3);
    check("t6_a5", readdata, 32'hA5);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h5A;
    repeat (16) tick();
    bus_read(3'd3);
    check("t6_5a", readdata, 32'hFF);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0)
        in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      reset = ($urandom_range(0, 999) == 0);
      address = 3'($urandom_range(0, 7));
      writedata = $urandom;
      if (address == 3'd6)
        writedata = (writedata & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
      chipselect = (r < 40);
      write_n = !(r < 25 || r >= 90);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
